// File: rtl/add_pipe_arbiter.sv
// Round-robin arbitrated 2-stage adder (fixed priority when ADD_PIPE_ARB_FIXED_PRIO_EN is defined) feeding an in-order result FIFO.
// Latency: accept in cycle T -> resp_valid earliest in T+3 (stage 0, stage 1, FIFO; no bypass).
// Backpressure: req_ready gated by a credit count over stage 0 + stage 1 + FIFO; resp holds until resp_ready.
module add_pipe_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*WIDTH-1:0]   req_y,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           resp_sum,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Reset shadow: keeps req_ready low on the first cycle after reset.
    logic             rst_q;

    // Pipeline stages
    logic             s0_vld;
    logic [WIDTH-1:0] s0_x;
    logic [WIDTH-1:0] s0_y;
    logic [ID_W-1:0]  s0_id;
    logic             s1_vld;
    logic [WIDTH-1:0] s1_sum;
    logic [ID_W-1:0]  s1_id;

    // Result FIFO
    logic [WIDTH-1:0] fifo_sum [FIFO_DEPTH];
    logic [ID_W-1:0]  fifo_id  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    logic [ID_W-1:0]  last_grant;

    // Arbitration / handshake
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic [CNT_W:0]   occ;
    logic             credit;
    logic             accept;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pick the winning requester: first valid one in search order.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ADD_PIPE_ARB_FIXED_PRIO_EN
            cand = ID_W'(k);
`else
            cand = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
`endif
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Credit check against registered occupancy; a pop this cycle does not free a slot yet.
    always_comb begin
        occ    = {{CNT_W{1'b0}}, s0_vld} + {{CNT_W{1'b0}}, s1_vld} + {1'b0, fifo_cnt};
        credit = (occ < (CNT_W + 1)'(FIFO_DEPTH));
        accept = gnt_found && credit && !rst && !rst_q;
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                sel_x = req_x[k*WIDTH +: WIDTH];
                sel_y = req_y[k*WIDTH +: WIDTH];
            end
        end
    end

    // Response side: FIFO head, zeroed when nothing is presented.
    always_comb begin
        resp_valid = (fifo_cnt != '0) && !rst;
        resp_id    = resp_valid ? fifo_id[rd_ptr]  : '0;
        resp_sum   = resp_valid ? fifo_sum[rd_ptr] : '0;
        busy       = (s0_vld || s1_vld || (fifo_cnt != '0)) && !rst;
        push       = s1_vld;
        pop        = resp_valid && resp_ready;
    end

    // Control state: valids, pointers, count, arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q      <= 1'b1;
            s0_vld     <= 1'b0;
            s1_vld     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            rst_q  <= 1'b0;
            s0_vld <= accept;
            s1_vld <= s0_vld;
            if (accept) begin
                last_grant <= gnt_idx;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Datapath registers and FIFO storage; qualified by the valids, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_x  <= sel_x;
            s0_y  <= sel_y;
            s0_id <= gnt_idx;
        end
        s1_sum <= s0_x + s0_y;
        s1_id  <= s0_id;
        if (push) begin
            fifo_sum[wr_ptr] <= s1_sum;
            fifo_id[wr_ptr]  <= s1_id;
        end
    end

endmodule

// File: doc/add_pipe_arbiter.md
ADD_PIPE_ARBITER -- requirements
Module: add_pipe_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, operand and sum width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (>=3).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester operand valid.
REQ-007 SHALL have port req_ready  out  NUM_REQ  per-requester accept (grant).
REQ-008 SHALL have port req_x  in  NUM_REQ*WIDTH  operand x; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_y  in  NUM_REQ*WIDTH  operand y; same packing as req_x.
REQ-010 SHALL have port resp_valid  out  1  result available.
REQ-011 SHALL have port resp_ready  in  1  consumer accepts result.
REQ-012 SHALL have port resp_id  out  clog2(NUM_REQ)  index of requester owning resp_sum.
REQ-013 SHALL have port resp_sum  out  WIDTH  x+y result.
REQ-014 SHALL have port busy  out  1  any operation in flight or queued.

Function
REQ-015 SHALL contain a 2-stage adder: stage 0 registers granted x, y, id, valid; stage 1 registers x+y mod 2^WIDTH with id, valid.
REQ-016 SHALL accept a request from i on a cycle where req_valid[i] and req_ready[i] are both high; at most one req_ready bit high per cycle.
REQ-017 SHALL drive req_ready[i] only when req_valid[i] high and credit available; req_ready may depend combinationally on req_valid.
REQ-018 SHALL define credit available as (stage-0 valid + stage-1 valid + fifo_count) < FIFO_DEPTH, using current-cycle register values; a same-cycle pop is not credited.
REQ-019 SHALL arbitrate round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on a grant.
REQ-020 SHALL push stage-1 result and id into the FIFO at the end of the cycle stage-1 valid is high; FIFO never overflows by REQ-018.
REQ-021 SHALL give fixed latency: request accepted in cycle T yields resp_valid high earliest in cycle T+3 (FIFO has no bypass).
REQ-022 SHALL present FIFO head on resp_id/resp_sum while resp_valid high; both driven 0 when resp_valid low.
REQ-023 SHALL pop on resp_valid and resp_ready; simultaneous push and pop leaves fifo_count unchanged; responses leave in acceptance order.
REQ-024 SHALL hold resp_valid, resp_id, resp_sum stable while resp_valid high and resp_ready low.
REQ-025 SHALL sustain one accept per cycle when resp_ready held high and FIFO_DEPTH>=4.
REQ-026 SHALL drive busy = stage-0 valid | stage-1 valid | (fifo_count != 0).

Reset
REQ-027 SHALL on rst clear stage valids, fifo_count, FIFO pointers; set last_grant to NUM_REQ-1 so requester 0 wins first.
REQ-028 SHALL hold req_ready all 0, resp_valid 0, resp_id 0, resp_sum 0, busy 0 during and on the cycle after rst.
REQ-029 SHALL discard in-flight and queued results on rst asserted mid-operation; none are ever emitted.

Configuration
REQ-030 SHALL, with ADD_PIPE_ARB_FIXED_PRIO_EN defined, grant lowest-index valid requester, ignoring last_grant.
REQ-031 SHALL, without ADD_PIPE_ARB_FIXED_PRIO_EN, use round-robin per REQ-019; all other behaviour identical.

Verification
REQ-032 SHALL cover: single request i=2, x=5, y=7, accepted cycle T, resp_ready=1 -> resp_valid in T+3, resp_id=2, resp_sum=12, busy low by T+4.
REQ-033 SHALL cover: x=0xFFFFFFFF, y=2 -> resp_sum=0x00000001 (wrap).
REQ-034 SHALL cover: all 4 requesters valid continuously, round-robin build -> grants 0,1,2,3,0,... one per cycle, responses in same id order; fixed-prio build -> only requester 0 granted.
REQ-035 SHALL cover: resp_ready=0, continuous requests -> exactly 4 accepts, then req_ready all 0; resp_ready=1 -> 4 responses in order, accepts resume.
REQ-036 SHALL cover: rst asserted one cycle with 2 ops in flight and 1 queued -> no resp_valid afterward until new request; next grant goes to requester 0.
